dmem_arbiter: RTL and testbench

//  Two-port round-robin arbiter/sequencer for the single-ported 32x32 data memory.

---
 rtl/dmem_arbiter.sv | 143 ++++++++++++++
 tb/tb_dmem_arbiter.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_arbiter.sv
// Two-port round-robin arbiter/sequencer for a single-ported 32x32 data memory.
// Port 0 is the CPU load/store unit, port 1 the debug/DMA loader. Each access runs
// IDLE -> GRANT -> RESP: the request is captured in IDLE, the memory port is driven
// for exactly one cycle in GRANT, and a registered response is returned in RESP.
module dmem_arbiter #(
  parameter int unsigned AW     = 32,
  parameter int unsigned DW     = 32,
  parameter bit          CHK_AL = 1'b1
) (
  input  logic          clk,
  input  logic          clrn,

  input  logic          r0_req,
  input  logic          r0_we,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  output logic          r0_err,

  input  logic          r1_req,
  input  logic          r1_we,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic          r1_err,

  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_we,
  input  logic [DW-1:0] mem_rdata,

  output logic          busy
);

  typedef enum logic [1:0] {StIdle, StGrant, StResp} state_e;

  state_e        state;
  logic          last;       // port granted most recently; the other port wins a tie
  logic          win;        // port owning the access in flight
  logic          lat_we;
  logic [AW-1:0] lat_addr;
  logic [DW-1:0] lat_wdata;
  logic          err_flag;   // latched request is misaligned; memory write suppressed

  logic          pick;
  logic          sel_we;
  logic [AW-1:0] sel_addr;
  logic [DW-1:0] sel_wdata;
  logic          sel_mis;

  // Winner selection and mux of the winning request's fields.
  always_comb begin
    pick      = 1'b0;
    sel_we    = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    sel_mis   = 1'b0;
    if (r0_req && r1_req) begin
      pick = ~last;
    end else begin
      pick = r1_req;
    end
    if (pick) begin
      sel_we    = r1_we;
      sel_addr  = r1_addr;
      sel_wdata = r1_wdata;
    end else begin
      sel_we    = r0_we;
      sel_addr  = r0_addr;
      sel_wdata = r0_wdata;
    end
    sel_mis = CHK_AL && (sel_addr[1:0] != 2'b00);
  end

  // Memory port: address/data hold the latched request (so they keep their last value
  // outside GRANT); the write strobe is decoded from state and dies with reset instantly.
  always_comb begin
    mem_addr  = lat_addr;
    mem_wdata = lat_wdata;
    mem_we    = (state == StGrant) && lat_we && !err_flag;
    busy      = (state != StIdle);
  end

  // Sequencer FSM with registered per-port responses.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state     <= StIdle;
      last      <= 1'b1;
      win       <= 1'b0;
      lat_we    <= 1'b0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      err_flag  <= 1'b0;
      r0_ack    <= 1'b0;
      r0_rdata  <= '0;
      r0_err    <= 1'b0;
      r1_ack    <= 1'b0;
      r1_rdata  <= '0;
      r1_err    <= 1'b0;
    end else begin
      unique case (state)
        StIdle: begin
          if (r0_req || r1_req) begin
            win       <= pick;
            last      <= pick;
            lat_we    <= sel_we;
            lat_addr  <= sel_addr;
            lat_wdata <= sel_wdata;
            err_flag  <= sel_mis;
            state     <= StGrant;
          end
        end
        StGrant: begin
          // Read data is sampled in the same cycle as a write, so writes return the old word.
          if (win) begin
            r1_ack   <= 1'b1;
            r1_rdata <= mem_rdata;
            r1_err   <= err_flag;
          end else begin
            r0_ack   <= 1'b1;
            r0_rdata <= mem_rdata;
            r0_err   <= err_flag;
          end
          state <= StResp;
        end
        StResp: begin
          // Requests are not looked at here; the requester drops req after seeing ack.
          r0_ack <= 1'b0;
          r0_err <= 1'b0;
          r1_ack <= 1'b0;
          r1_err <= 1'b0;
          state  <= StIdle;
        end
        default: begin
          state <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter: a behavioural 32x32 RAM on the memory port, a shadow
// model of the RAM contents and a response scoreboard filled in expected grant order.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        clrn;
  logic        r0_req, r0_we, r0_ack, r0_err;
  logic [31:0] r0_addr, r0_wdata, r0_rdata;
  logic        r1_req, r1_we, r1_ack, r1_err;
  logic [31:0] r1_addr, r1_wdata, r1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_we, busy;

  dmem_arbiter #(.AW(32), .DW(32), .CHK_AL(1'b1)) dut (
    .clk(clk), .clrn(clrn),
    .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata), .r0_err(r0_err),
    .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata), .r1_err(r1_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // RAM: combinational read, clocked write; tb_we is a backdoor preload port.
  logic [31:0] ram [32];
  logic        tb_we;
  logic [4:0]  tb_idx;
  logic [31:0] tb_data;
  assign mem_rdata = ram[mem_addr[6:2]];
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr[6:2]] <= mem_wdata;
    else if (tb_we) ram[tb_idx] <= tb_data;
  end

  typedef struct {
    int          port;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] model [32];
  int          errors = 0;
  int          checks = 0;
  int          ack_port;
  logic        we_seen;

  function automatic logic [31:0] init_val(input int i);
    case (i)
      20:      return 32'h0000_00A3;
      22:      return 32'h0000_0079;
      23:      return 32'h0000_0115;
      default: return 32'hC0DE_0000 | 32'(i);
    endcase
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  // Expected response for an access, computed from the shadow model in grant order.
  task automatic push(input int port, input logic we, input logic [31:0] addr,
                      input logic [31:0] wdata);
    exp_t e;
    logic mis;
    mis     = (addr[1:0] != 2'b00);
    e.port  = port;
    e.rdata = model[addr[6:2]];
    e.err   = mis;
    if (we && !mis) model[addr[6:2]] = wdata;
    sb.push_back(e);
  endtask

  task automatic set_req(input int port, input logic req, input logic we,
                         input logic [31:0] addr, input logic [31:0] wdata);
    if (port == 0) begin
      r0_req = req; r0_we = we; r0_addr = addr; r0_wdata = wdata;
    end else begin
      r1_req = req; r1_we = we; r1_addr = addr; r1_wdata = wdata;
    end
  endtask

  // Advance to the next falling edge and score any response present there.
  task automatic tick();
    exp_t e;
    @(negedge clk);
    ack_port = -1;
    if (mem_we) we_seen = 1'b1;
    if (r0_ack || r1_ack) begin
      ack_port = r1_ack ? 1 : 0;
      chk("one_ack_at_a_time", 32'(r0_ack & r1_ack), 32'd0);
      chk("ack_expected", 32'(sb.size() == 0), 32'd0);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("ack_port", 32'(ack_port), 32'(e.port));
        chk("rdata", (ack_port == 1) ? r1_rdata : r0_rdata, e.rdata);
        chk("err", 32'((ack_port == 1) ? r1_err : r0_err), 32'(e.err));
      end
    end
  endtask

  // Single access from an idle arbiter; ack must arrive two falling edges after driving req.
  task automatic do_access(input int port, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata);
    int lat;
    lat = 0;
    push(port, we, addr, wdata);
    set_req(port, 1'b1, we, addr, wdata);
    for (int k = 1; k <= 8 && lat == 0; k++) begin
      tick();
      if (ack_port == port) lat = k;
    end
    chk("ack_latency", 32'(lat), 32'd2);
    set_req(port, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, t0, t1;
    clrn    = 1'b0;
    we_seen = 1'b0;
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    tb_we   = 1'b1;
    tb_idx  = '0;
    tb_data = '0;
    for (int i = 0; i < 32; i++) begin
      tb_idx   = 5'(i);
      tb_data  = init_val(i);
      model[i] = init_val(i);
      @(negedge clk);
    end
    tb_we = 1'b0;

    // Reset state
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_acks", 32'({r0_ack, r1_ack}), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    chk("rst_mem_addr", mem_addr, 32'd0);
    chk("rst_r0_rdata", r0_rdata, 32'd0);
    chk("rst_r1_rdata", r1_rdata, 32'd0);
    clrn = 1'b1;
    tick();

    // 1: reset in the middle of a port-0 write's GRANT cycle
    set_req(0, 1'b1, 1'b1, 32'h50, 32'hDEAD_BEEF);
    tick();
    chk("grant_mem_we", 32'(mem_we), 32'd1);
    chk("grant_mem_addr", mem_addr, 32'h50);
    chk("grant_busy", 32'(busy), 32'd1);
    clrn = 1'b0;
    #1;
    chk("abort_mem_we", 32'(mem_we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_acks", 32'({r0_ack, r1_ack}), 32'd0);
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    tick();
    tick();
    chk("abort_ram_unchanged", ram[5'h14], 32'h0000_00A3);
    clrn = 1'b1;
    tick();

    // 2: single read
    do_access(0, 1'b0, 32'h50, 32'd0);
    chk("r0_rdata_hold", r0_rdata, 32'h0000_00A3);
    chk("r0_ack_low", 32'(r0_ack), 32'd0);

    // 3: write then read back on port 1
    do_access(1, 1'b1, 32'h54, 32'h1234_5678);
    do_access(1, 1'b0, 32'h54, 32'd0);
    chk("r1_readback", r1_rdata, 32'h1234_5678);

    // 4: continuous contention -> 0,1,0,1,0,1
    for (int i = 0; i < 3; i++) begin
      push(0, 1'b0, 32'h58, 32'd0);
      push(1, 1'b0, 32'h5C, 32'd0);
    end
    set_req(0, 1'b1, 1'b0, 32'h58, 32'd0);
    set_req(1, 1'b1, 1'b0, 32'h5C, 32'd0);
    n = 0;
    for (int k = 0; k < 30 && n < 6; k++) begin
      tick();
      if (ack_port >= 0) n++;
    end
    set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
    set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
    chk("contention_acks", 32'(n), 32'd6);
    tick();

    // 5: misaligned write is rejected without touching memory
    we_seen = 1'b0;
    do_access(0, 1'b1, 32'h52, 32'hFFFF_0000);
    chk("misaligned_no_we", 32'(we_seen), 32'd0);
    chk("misaligned_ram", ram[5'h14], 32'h0000_00A3);

    // 6: port-1 request arriving during port-0 GRANT is served in the following slot
    push(0, 1'b0, 32'h58, 32'd0);
    push(1, 1'b0, 32'h5C, 32'd0);
    set_req(0, 1'b1, 1'b0, 32'h58, 32'd0);
    tick();
    set_req(1, 1'b1, 1'b0, 32'h5C, 32'd0);
    t0 = 0;
    t1 = 0;
    for (int k = 2; k <= 14 && t1 == 0; k++) begin
      tick();
      if (ack_port == 0) begin
        t0 = k;
        set_req(0, 1'b0, 1'b0, 32'd0, 32'd0);
      end
      if (ack_port == 1) begin
        t1 = k;
        set_req(1, 1'b0, 1'b0, 32'd0, 32'd0);
      end
    end
    chk("late_r0_ack_cycle", 32'(t0), 32'd2);
    chk("late_r1_gap", 32'(t1 - t0), 32'd3);
    tick();

    chk("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
